// File: rtl/dna_reader.sv
// Streams one network's genes out of word-addressed RAM through a valid/ready handshake.
// Define DNA_READER_GENE_CHECK_EN to zero out-of-range genes and raise a sticky error.
module dna_reader #(
  parameter int unsigned INPUT_COUNT             = 1,
  parameter int unsigned OUTPUT_COUNT            = 1,
  parameter int unsigned NEURON_COUNT            = 2,
  parameter int unsigned CONNECTIONS             = 2,
  parameter int unsigned NETWORKS_PER_POPULATION = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  network_state_i,
  input  logic        start_i,
  input  logic [7:0]  network_index_i,
  inout  logic [22:0] ram_bus_addr_io,
  inout  logic        ram_latch_io,
  inout  logic        ram_instruction_io,
  input  logic        ram_ready_i,
  input  logic [15:0] ram_bus_data_out_i,
  output logic [15:0] gene_o,
  output logic [15:0] gene_index_o,
  output logic        gene_valid_o,
  input  logic        gene_ready_i,
  output logic        busy_o,
  output logic        finished_o,
  output logic        gene_error_o
);

  localparam int unsigned G         = OUTPUT_COUNT + NEURON_COUNT * CONNECTIONS;
  localparam logic [22:0] GWord     = 23'(G);
  localparam logic [15:0] KLast     = 16'(G - 1);
  localparam int unsigned GeneLimit = OUTPUT_COUNT + NEURON_COUNT + 1;

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitBusy, StWaitData, StPresent, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] k_q, k_d;
  logic [15:0] gene_q, gene_d;
  logic        gene_valid_q, gene_valid_d;
  logic        armed_q;
  logic        own;
  logic        idx_ok;
  logic [22:0] base_addr;
  logic [15:0] captured;
  logic        capture_en;
  logic        unused_cfg;

  assign unused_cfg = (INPUT_COUNT == 0);

  assign own       = (network_state_i == 2'd1);
  assign idx_ok    = (32'(network_index_i) < NETWORKS_PER_POPULATION);
  assign base_addr = 23'(network_index_i) * GWord + 23'd1;

`ifdef DNA_READER_GENE_CHECK_EN
  logic gene_error_q;
  logic out_of_range;

  assign out_of_range = (32'(ram_bus_data_out_i) >= GeneLimit);
  assign captured     = out_of_range ? 16'd0 : ram_bus_data_out_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gene_error_q <= 1'b0;
    end else if (capture_en && out_of_range) begin
      gene_error_q <= 1'b1;
    end
  end

  assign gene_error_o = gene_error_q;
`else
  logic unused_limit;

  assign unused_limit = (GeneLimit == 0);
  assign captured     = ram_bus_data_out_i;
  assign gene_error_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    k_d          = k_q;
    gene_d       = gene_q;
    gene_valid_d = gene_valid_q;
    capture_en   = 1'b0;
    if (state_q != StIdle && !own) begin
      // Losing the bus abandons the fetch silently.
      state_d      = StIdle;
      gene_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && own && armed_q && idx_ok) begin
            addr_d  = base_addr;
            k_d     = 16'd0;
            state_d = StIssue;
          end
        end
        StIssue: state_d = StWaitBusy;
        StWaitBusy: begin
          if (!ram_ready_i) state_d = StWaitData;
        end
        StWaitData: begin
          if (ram_ready_i) begin
            capture_en   = 1'b1;
            gene_d       = captured;
            gene_valid_d = 1'b1;
            state_d      = StPresent;
          end
        end
        StPresent: begin
          if (gene_ready_i) begin
            gene_valid_d = 1'b0;
            if (k_q == KLast) begin
              state_d = StDone;
            end else begin
              k_d     = k_q + 16'd1;
              addr_d  = addr_q + 23'd1;
              state_d = StIssue;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= 23'd0;
      k_q          <= 16'd0;
      gene_q       <= 16'd0;
      gene_valid_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      k_q          <= k_d;
      gene_q       <= gene_d;
      gene_valid_q <= gene_valid_d;
      armed_q      <= 1'b1;
    end
  end

  assign gene_o       = gene_q;
  assign gene_index_o = k_q;
  assign gene_valid_o = gene_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign finished_o   = (state_q == StDone) && own;

  assign ram_bus_addr_io    = own ? addr_q : 'z;
  assign ram_latch_io       = own ? (state_q == StIssue) : 1'bz;
  assign ram_instruction_io = own ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dna_reader.sv
// Directed bench for dna_reader with a small latch/ready RAM model.
module tb_dna_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  network_state;
  logic        start;
  logic [7:0]  network_index;
  wire  [22:0] ram_bus_addr;
  wire         ram_latch;
  wire         ram_instruction;
  logic        ram_ready = 1'b1;
  logic [15:0] ram_data = 16'd0;
  logic [15:0] gene;
  logic [15:0] gene_index;
  logic        gene_valid;
  logic        gene_ready;
  logic        busy;
  logic        finished;
  logic        gene_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:127];
  logic        pend = 1'b0;
  logic [22:0] paddr = 23'd0;
  logic [22:0] latch_log [$];

  logic [15:0] got_genes [$];
  logic [15:0] got_idx [$];
  int          fin_cnt;
  int          first_lat;
  logic        timed_out;

  always #5 clk = ~clk;

  pullup (ram_latch);
  pullup (ram_instruction);
  for (genvar i = 0; i < 23; i++) begin : g_pu
    pullup (ram_bus_addr[i]);
  end

  dna_reader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .network_state_i    (network_state),
    .start_i            (start),
    .network_index_i    (network_index),
    .ram_bus_addr_io    (ram_bus_addr),
    .ram_latch_io       (ram_latch),
    .ram_instruction_io (ram_instruction),
    .ram_ready_i        (ram_ready),
    .ram_bus_data_out_i (ram_data),
    .gene_o             (gene),
    .gene_index_o       (gene_index),
    .gene_valid_o       (gene_valid),
    .gene_ready_i       (gene_ready),
    .busy_o             (busy),
    .finished_o         (finished),
    .gene_error_o       (gene_error)
  );

  // RAM: busy the cycle after a latch, data and ready the cycle after that.
  always @(posedge clk) begin
    if (network_state == 2'd1 && ram_latch === 1'b1) begin
      ram_ready <= 1'b0;
      pend      <= 1'b1;
      paddr     <= ram_bus_addr;
      latch_log.push_back(ram_bus_addr);
    end else if (pend) begin
      ram_ready <= 1'b1;
      ram_data  <= mem[paddr[6:0]];
      pend      <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a fetch and collects genes until finished; optional stray start at cycle intrude_at.
  task automatic run_fetch(input logic [7:0] idx, input int intrude_at);
    int cyc;
    got_genes.delete();
    got_idx.delete();
    latch_log.delete();
    fin_cnt   = 0;
    first_lat = -1;
    timed_out = 1'b1;
    network_index = idx;
    start = 1'b1;
    step();
    start = 1'b0;
    for (cyc = 1; cyc < 200; cyc++) begin
      if (cyc == intrude_at) begin
        start = 1'b1;
        network_index = 8'd3;
      end else begin
        start = 1'b0;
        network_index = idx;
      end
      if (gene_valid) begin
        if (first_lat < 0) first_lat = cyc;
        got_genes.push_back(gene);
        got_idx.push_back(gene_index);
      end
      if (finished) begin
        fin_cnt++;
        timed_out = 1'b0;
        break;
      end
      step();
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (finished) fin_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    network_state = 2'd1;
    start = 1'b0;
    network_index = 8'd0;
    gene_ready = 1'b1;
    step();
    step();
    n_checks++; if (gene !== 16'd0) begin n_fail++; $display("FAIL reset_gene got %0d want 0", gene); end
    n_checks++; if (gene_index !== 16'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", gene_index); end
    n_checks++; if (gene_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", gene_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (finished !== 1'b0) begin n_fail++; $display("FAIL reset_finished got %b want 0", finished); end
    n_checks++; if (gene_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", gene_error); end
    n_checks++; if (ram_latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch got %b want 0", ram_latch); end
    n_checks++; if (ram_bus_addr !== 23'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", ram_bus_addr); end
    n_checks++; if (ram_instruction !== 1'b0) begin n_fail++; $display("FAIL reset_instr got %b want 0", ram_instruction); end
  endtask

  task automatic test_start_window();
    latch_log.delete();
    rst_n = 1'b1;
    start = 1'b1;
    network_index = 8'd0;
    step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_edge_start got busy=%b want 0", busy); end
    step();
    step();
    n_checks++; if (latch_log.size() != 0) begin n_fail++; $display("FAIL first_edge_latch got %0d latches want 0", latch_log.size()); end
  endtask

  task automatic test_fetch();
    logic [15:0] exp [5];
    exp = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd2};
    run_fetch(8'd0, 6);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL fetch_timeout got timeout want finished"); end
    n_checks++; if (first_lat != 4) begin n_fail++; $display("FAIL fetch_latency got %0d want 4", first_lat); end
    n_checks++; if (got_genes.size() != 5) begin n_fail++; $display("FAIL fetch_count got %0d want 5", got_genes.size()); end
    n_checks++; if (latch_log.size() != 5) begin n_fail++; $display("FAIL fetch_latches got %0d want 5", latch_log.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got_genes.size()) begin
        n_checks++; if (got_genes[i] !== exp[i]) begin n_fail++; $display("FAIL fetch_gene%0d got %0d want %0d", i, got_genes[i], exp[i]); end
        n_checks++; if (got_idx[i] !== 16'(i)) begin n_fail++; $display("FAIL fetch_index%0d got %0d want %0d", i, got_idx[i], i); end
      end
      if (i < latch_log.size()) begin
        n_checks++; if (latch_log[i] !== 23'(i + 1)) begin n_fail++; $display("FAIL fetch_addr%0d got %0d want %0d", i, latch_log[i], i + 1); end
      end
    end
    n_checks++; if (fin_cnt != 1) begin n_fail++; $display("FAIL fetch_finished got %0d pulses want 1", fin_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_after got %b want 0", busy); end
  endtask

  task automatic test_bounds();
    run_fetch(8'd15, 0);
    n_checks++; if (latch_log.size() != 5) begin n_fail++; $display("FAIL idx15_latches got %0d want 5", latch_log.size()); end
    if (latch_log.size() == 5) begin
      n_checks++; if (latch_log[0] !== 23'd76) begin n_fail++; $display("FAIL idx15_first got %0d want 76", latch_log[0]); end
      n_checks++; if (latch_log[4] !== 23'd80) begin n_fail++; $display("FAIL idx15_last got %0d want 80", latch_log[4]); end
    end
    n_checks++; if (got_genes.size() != 5 || got_genes[4] !== 16'd3) begin n_fail++; $display("FAIL idx15_genes got %0d genes want 5 ending 3", got_genes.size()); end
    latch_log.delete();
    network_index = 8'd16;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idx16_busy got %b want 0", busy); end
    step();
    step();
    n_checks++; if (latch_log.size() != 0) begin n_fail++; $display("FAIL idx16_latches got %0d want 0", latch_log.size()); end
  endtask

  task automatic test_stall();
    logic [15:0] g_hold;
    int          n_lat;
    int          cyc;
    logic        bad;
    latch_log.delete();
    network_index = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (cyc = 0; cyc < 100; cyc++) begin
      if (gene_valid && gene_index == 16'd2) break;
      step();
    end
    n_checks++; if (cyc >= 100) begin n_fail++; $display("FAIL stall_reach got timeout want gene 2"); end
    gene_ready = 1'b0;
    g_hold = gene;
    n_lat = latch_log.size();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gene !== g_hold || gene_index !== 16'd2 || gene_valid !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL stall_stable got gene=%0d idx=%0d valid=%b want %0d/2/1", gene, gene_index, gene_valid, g_hold); end
    n_checks++; if (g_hold !== 16'd3) begin n_fail++; $display("FAIL stall_gene got %0d want 3", g_hold); end
    n_checks++; if (latch_log.size() != n_lat) begin n_fail++; $display("FAIL stall_latch got %0d latches want %0d", latch_log.size(), n_lat); end
    gene_ready = 1'b1;
    step();
    n_checks++; if (gene_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop got %b want 0", gene_valid); end
    for (cyc = 0; cyc < 100 && !finished; cyc++) step();
    n_checks++; if (!finished) begin n_fail++; $display("FAIL stall_finish got no pulse want pulse"); end
    step();
  endtask

  task automatic test_abort();
    int fins;
    network_index = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    network_state = 2'd0;
    #1;
    n_checks++; if (ram_latch !== 1'b1) begin n_fail++; $display("FAIL abort_latch_release got %b want pulled 1", ram_latch); end
    n_checks++; if (ram_instruction !== 1'b1) begin n_fail++; $display("FAIL abort_instr_release got %b want pulled 1", ram_instruction); end
    n_checks++; if (ram_bus_addr !== 23'h7fffff) begin n_fail++; $display("FAIL abort_addr_release got %h want 7fffff", ram_bus_addr); end
    fins = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (finished) fins++;
    end
    n_checks++; if (gene_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", gene_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (fins != 0) begin n_fail++; $display("FAIL abort_finished got %0d want 0", fins); end
    network_state = 2'd1;
    step();
    run_fetch(8'd1, 0);
    n_checks++; if (got_genes.size() != 5 || fin_cnt != 1) begin n_fail++; $display("FAIL abort_refetch got %0d genes %0d fin want 5 1", got_genes.size(), fin_cnt); end
    n_checks++; if (got_genes.size() > 2 && got_genes[0] !== 16'd3) begin n_fail++; $display("FAIL abort_refetch_gene got %0d want 3", got_genes[0]); end
  endtask

  task automatic test_reset_mid();
    int fins;
    network_index = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_checks++; if (gene !== 16'd0) begin n_fail++; $display("FAIL midreset_gene got %0d want 0", gene); end
    step();
    rst_n = 1'b1;
    fins = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (finished || busy) fins++;
    end
    n_checks++; if (fins != 0) begin n_fail++; $display("FAIL midreset_activity got %0d cycles want 0", fins); end
  endtask

  task automatic test_gene_check();
    mem[1] = 16'd7;
    run_fetch(8'd0, 0);
    mem[1] = 16'd1;
`ifdef DNA_READER_GENE_CHECK_EN
    n_checks++; if (got_genes.size() < 1 || got_genes[0] !== 16'd0) begin n_fail++; $display("FAIL check_gene got %0d want 0", got_genes.size() > 0 ? got_genes[0] : 16'hffff); end
    n_checks++; if (gene_error !== 1'b1) begin n_fail++; $display("FAIL check_error got %b want 1", gene_error); end
    step();
    step();
    n_checks++; if (gene_error !== 1'b1) begin n_fail++; $display("FAIL check_sticky got %b want 1", gene_error); end
`else
    n_checks++; if (got_genes.size() < 1 || got_genes[0] !== 16'd7) begin n_fail++; $display("FAIL pass_gene got %0d want 7", got_genes.size() > 0 ? got_genes[0] : 16'hffff); end
    n_checks++; if (gene_error !== 1'b0) begin n_fail++; $display("FAIL pass_error got %b want 0", gene_error); end
`endif
    rst_n = 1'b0;
    step();
    n_checks++; if (gene_error !== 1'b0) begin n_fail++; $display("FAIL check_error_reset got %b want 0", gene_error); end
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'd0;
    mem[1] = 16'd1;  mem[2] = 16'd2;  mem[3] = 16'd3;  mem[4] = 16'd0;  mem[5] = 16'd2;
    mem[6] = 16'd3;  mem[7] = 16'd1;  mem[8] = 16'd0;  mem[9] = 16'd2;  mem[10] = 16'd1;
    mem[76] = 16'd2; mem[77] = 16'd3; mem[78] = 16'd1; mem[79] = 16'd0; mem[80] = 16'd3;
    test_reset();
    test_start_window();
    test_fetch();
    test_bounds();
    test_stall();
    test_abort();
    test_reset_mid();
    test_gene_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
